// File: rtl/neuron_sample_feeder_pkg.sv
// Shared constants for the neuron sample feeder: FSM encoding, default
// sample field widths and the width of the sample-count bus.
package neuron_sample_feeder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_FEED  = 2'd2;

  localparam int XW_DEF = 7;
  localparam int TW_DEF = 2;
  localparam int NBUS_W = 32;

endpackage

// File: rtl/neuron_sample_feeder_sample_table.sv
// Training sample storage: one synchronous write port, one asynchronous read port.
module sample_table #(
  parameter  int DEPTH = 64,
  parameter  int SW    = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [SW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [SW-1:0] rd_data
);

  logic [SW-1:0] mem_q [DEPTH];
  logic [SW-1:0] mem_d [DEPTH];

  // Addresses past the last entry only exist when DEPTH is not a power of two.
  always_comb begin
    mem_d = mem_q;
    if (we && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/neuron_sample_feeder.sv
// Producer side of the neuron training handshake: pulses start, then presents
// one table sample per readyToGetData, epoch after epoch, until done or timeout.
module neuron_sample_feeder
  import neuron_sample_feeder_pkg::*;
#(
  parameter  int DEPTH      = 64,
  parameter  int XW         = XW_DEF,
  parameter  int TW         = TW_DEF,
  parameter  int MAX_EPOCHS = 1000,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [XW-1:0]     cfg_x1,
  input  logic [XW-1:0]     cfg_x2,
  input  logic [TW-1:0]     cfg_t,
  input  logic [AW:0]       sample_count,
  input  logic              go,
  input  logic              readyToGetData,
  input  logic              reinitializingState,
  input  logic              done,
  output logic [XW-1:0]     X1Bus,
  output logic [XW-1:0]     X2Bus,
  output logic [TW-1:0]     tBus,
  output logic [NBUS_W-1:0] nBus,
  output logic              start,
  output logic              busy,
  output logic              train_done,
  output logic              timeout,
  output logic [15:0]       epoch_cnt,
  output state_t            state_dbg
);

  localparam int SW = 2*XW + TW;

  // Handshake: the buses are registered and change only on the edge where the
  // neuron consumes (readyToGetData) or restarts (reinitializingState), so the
  // value visible while readyToGetData is high is the value the neuron latches.

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   count_q, count_d;
  logic [XW-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [TW-1:0] t_q, t_d;
  logic [15:0]   epoch_q, epoch_d;
  logic          timeout_q, timeout_d;
  logic          train_done_q, train_done_d;
  logic          load, bump, count_ok;
  logic [SW-1:0] rd_data;

  assign count_ok = (sample_count != '0) && (sample_count <= (AW+1)'(DEPTH));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    epoch_d      = epoch_q;
    timeout_d    = timeout_q;
    train_done_d = 1'b0;
    load         = 1'b0;
    bump         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go && count_ok) begin
          count_d   = sample_count;
          idx_d     = '0;
          epoch_d   = '0;
          timeout_d = 1'b0;
          load      = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: state_d = ST_FEED;
      ST_FEED: begin
        if (done) begin
          state_d      = ST_IDLE;
          train_done_d = 1'b1;
        end else begin
          if (reinitializingState) begin
            idx_d = '0;
            load  = 1'b1;
            bump  = (idx_q != '0);
          end else if (readyToGetData) begin
            load = 1'b1;
            if ({1'b0, idx_q} == count_q - (AW+1)'(1)) begin
              idx_d = '0;
              bump  = 1'b1;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end
          if (bump && (epoch_q != 16'hFFFF)) begin
            epoch_d = epoch_q + 16'd1;
          end
          if (32'(epoch_d) >= 32'(MAX_EPOCHS)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The read port follows the next index, so a load captures the sample the
  // buses must show after this edge.
  always_comb begin
    x1_d = x1_q;
    x2_d = x2_q;
    t_d  = t_q;
    if (load) begin
      {x1_d, x2_d, t_d} = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      x1_q         <= '0;
      x2_q         <= '0;
      t_q          <= '0;
      epoch_q      <= '0;
      timeout_q    <= 1'b0;
      train_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      t_q          <= t_d;
      epoch_q      <= epoch_d;
      timeout_q    <= timeout_d;
      train_done_q <= train_done_d;
    end
  end

  sample_table #(
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_table (
    .clk     (clk),
    .we      (cfg_we && (state_q == ST_IDLE) && !rst),
    .wr_addr (cfg_addr),
    .wr_data ({cfg_x1, cfg_x2, cfg_t}),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

  assign X1Bus      = x1_q;
  assign X2Bus      = x2_q;
  assign tBus       = t_q;
  assign nBus       = NBUS_W'(count_q);
  assign start      = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);
  assign train_done = train_done_q;
  assign timeout    = timeout_q;
  assign epoch_cnt  = epoch_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Directed and randomized bench for neuron_sample_feeder, checked against a
// transaction-level model of the sample table and epoch rules.
module tb_neuron_sample_feeder;
  import neuron_sample_feeder_pkg::*;

  localparam int DEPTH      = 64;
  localparam int XW         = 7;
  localparam int TW         = 2;
  localparam int MAX_EPOCHS = 3;
  localparam int AW         = 6;
  localparam int SW         = 2*XW + TW;

  // clock / reset / stimulus signals
  logic          clk = 1'b0;
  logic          rst, cfg_we, go, rdy, reinit, done;
  logic [AW-1:0] cfg_addr;
  logic [XW-1:0] cfg_x1, cfg_x2;
  logic [TW-1:0] cfg_t;
  logic [AW:0]   sample_count;

  logic [XW-1:0] X1Bus, X2Bus;
  logic [TW-1:0] tBus;
  logic [31:0]   nBus;
  logic          start, busy, train_done, timeout;
  logic [15:0]   epoch_cnt;
  state_t        state_dbg;

  always #5 clk = ~clk;

  neuron_sample_feeder #(
    .DEPTH(DEPTH), .XW(XW), .TW(TW), .MAX_EPOCHS(MAX_EPOCHS)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_x1(cfg_x1), .cfg_x2(cfg_x2), .cfg_t(cfg_t),
    .sample_count(sample_count), .go(go),
    .readyToGetData(rdy), .reinitializingState(reinit), .done(done),
    .X1Bus(X1Bus), .X2Bus(X2Bus), .tBus(tBus), .nBus(nBus),
    .start(start), .busy(busy), .train_done(train_done),
    .timeout(timeout), .epoch_cnt(epoch_cnt), .state_dbg(state_dbg)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a run is either inactive, in its start cycle, or feeding.
  logic [SW-1:0] m_tab [DEPTH];
  bit            m_active, m_in_start, m_timeout, m_td;
  int            m_idx, m_count, m_epoch;
  logic [XW-1:0] m_x1, m_x2;
  logic [TW-1:0] m_t;

  task automatic model_edge();
    bit ep;
    m_td = 1'b0;
    if (rst) begin
      m_active = 0; m_in_start = 0; m_idx = 0; m_count = 0;
      m_epoch = 0; m_timeout = 0; {m_x1, m_x2, m_t} = '0;
      return;
    end
    if (!m_active) begin
      if (go && sample_count >= 1 && sample_count <= DEPTH) begin
        m_active = 1; m_in_start = 1; m_count = int'(sample_count);
        m_idx = 0; m_epoch = 0; m_timeout = 0;
        {m_x1, m_x2, m_t} = m_tab[0];
      end
      if (cfg_we && int'(cfg_addr) < DEPTH) m_tab[cfg_addr] = {cfg_x1, cfg_x2, cfg_t};
    end else if (m_in_start) begin
      m_in_start = 0;
    end else if (done) begin
      m_active = 0;
      m_td = 1;
    end else begin
      ep = 0;
      if (reinit) begin
        ep = (m_idx != 0);
        m_idx = 0;
      end else if (rdy) begin
        m_idx = (m_idx + 1) % m_count;
        ep = (m_idx == 0);
      end
      if (reinit || rdy) {m_x1, m_x2, m_t} = m_tab[m_idx];
      if (ep && m_epoch < 65535) m_epoch++;
      if (m_epoch >= MAX_EPOCHS) begin
        m_timeout = 1;
        m_active = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("x1",         32'(X1Bus),      32'(m_x1));
    chk("x2",         32'(X2Bus),      32'(m_x2));
    chk("t",          32'(tBus),       32'(m_t));
    chk("nbus",       nBus,            32'(m_count));
    chk("start",      32'(start),      32'(m_active && m_in_start));
    chk("busy",       32'(busy),       32'(m_active));
    chk("train_done", 32'(train_done), 32'(m_td));
    chk("timeout",    32'(timeout),    32'(m_timeout));
    chk("epoch",      32'(epoch_cnt),  32'(m_epoch));
  endtask

  // driver: one clock edge, model update at the edge, checks 1ns later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic write_sample(input int a, input logic [XW-1:0] x1, input logic [XW-1:0] x2,
                              input logic [TW-1:0] t);
    cfg_we = 1; cfg_addr = AW'(a); cfg_x1 = x1; cfg_x2 = x2; cfg_t = t;
    step();
    cfg_we = 0;
  endtask

  task automatic chk_bus(input string tag, input logic [XW-1:0] x1, input logic [XW-1:0] x2,
                         input logic [TW-1:0] t);
    chk({tag, "_x1"}, 32'(X1Bus), 32'(x1));
    chk({tag, "_x2"}, 32'(X2Bus), 32'(x2));
    chk({tag, "_t"},  32'(tBus),  32'(t));
  endtask

  task automatic go_pulse(input int cnt);
    sample_count = (AW+1)'(cnt); go = 1;
    step();
    go = 0;
  endtask

  initial begin
    rst = 1; cfg_we = 0; go = 0; rdy = 0; reinit = 0; done = 0;
    cfg_addr = '0; cfg_x1 = '0; cfg_x2 = '0; cfg_t = '0; sample_count = '0;
    step(); step();
    chk("rst_busy",  32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_nbus",  nBus, 0);
    chk("rst_epoch", 32'(epoch_cnt), 0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 0;

    // program (3,5,1) (-2,7,2) (10,0,1) (1,1,2)
    write_sample(0, 7'd3,  7'd5, 2'd1);
    write_sample(1, 7'h7E, 7'd7, 2'd2);
    write_sample(2, 7'd10, 7'd0, 2'd1);
    write_sample(3, 7'd1,  7'd1, 2'd2);

    go_pulse(4);
    chk("go_start", 32'(start), 1);
    chk("go_nbus", nBus, 4);
    chk_bus("go_s0", 7'd3, 7'd5, 2'd1);
    step();
    chk("start_once", 32'(start), 0);
    chk("feed_state", 32'(state_dbg), 32'(ST_FEED));

    rdy = 1;
    step(); chk_bus("c1", 7'h7E, 7'd7, 2'd2);
    step(); chk_bus("c2", 7'd10, 7'd0, 2'd1);
    step(); chk_bus("c3", 7'd1, 7'd1, 2'd2);
    step(); chk_bus("wrap", 7'd3, 7'd5, 2'd1);
    chk("wrap_epoch", 32'(epoch_cnt), 1);

    // reinit beats a simultaneous consume at index 2
    step(); step();
    reinit = 1;
    step();
    reinit = 0;
    chk_bus("reinit", 7'd3, 7'd5, 2'd1);
    chk("reinit_epoch", 32'(epoch_cnt), 2);
    step(); chk_bus("after_reinit", 7'h7E, 7'd7, 2'd2);
    rdy = 0;

    // done beats a simultaneous consume at index 1
    done = 1; rdy = 1;
    step();
    done = 0; rdy = 0;
    chk("done_td", 32'(train_done), 1);
    chk("done_busy", 32'(busy), 0);
    chk_bus("done_hold", 7'h7E, 7'd7, 2'd2);
    step();
    chk("td_pulse", 32'(train_done), 0);

    // epoch limit with count=2; go and cfg_we while busy are ignored
    go_pulse(2);
    chk("ep_cleared", 32'(epoch_cnt), 0);
    step();
    rdy = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        cfg_we = 1; cfg_addr = 6'd1; cfg_x1 = 7'h11; cfg_x2 = 7'h22; cfg_t = 2'd3;
        go = 1; sample_count = 7'd4;
      end else begin
        cfg_we = 0; go = 0;
      end
      step();
    end
    cfg_we = 0; go = 0; rdy = 0;
    chk("to_timeout", 32'(timeout), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_epoch", 32'(epoch_cnt), 3);
    chk("to_td", 32'(train_done), 0);

    go_pulse(2);
    chk("go_clears_to", 32'(timeout), 0);
    step();
    rdy = 1; step(); rdy = 0;
    chk_bus("tab_kept", 7'h7E, 7'd7, 2'd2);
    done = 1; step(); done = 0;

    // invalid counts
    go_pulse(0);
    chk("cnt0_start", 32'(start), 0);
    chk("cnt0_busy", 32'(busy), 0);
    go_pulse(DEPTH + 1);
    chk("cnt65_start", 32'(start), 0);
    step();
    chk("cnt65_busy", 32'(busy), 0);

    // reset mid-feed at index 3
    go_pulse(4);
    step();
    rdy = 1; step(); step(); step(); rdy = 0;
    chk_bus("idx3", 7'd1, 7'd1, 2'd2);
    rst = 1; step(); rst = 0;
    chk_bus("mid_rst", 7'd0, 7'd0, 2'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("mid_rst_nbus", nBus, 0);
    chk("mid_rst_start", 32'(start), 0);
    go_pulse(4);
    chk_bus("rerun_s0", 7'd3, 7'd5, 2'd1);
    step();
    done = 1; step(); done = 0;

    // randomized phase
    for (int a = 0; a < DEPTH; a++)
      write_sample(a, XW'($urandom), XW'($urandom), TW'($urandom));
    for (int n = 0; n < 3000; n++) begin
      go           = ($urandom_range(0, 7) == 0);
      sample_count = (AW+1)'($urandom_range(0, DEPTH + 2));
      rdy          = 1'($urandom_range(0, 1));
      reinit       = ($urandom_range(0, 15) == 0);
      done         = ($urandom_range(0, 40) == 0);
      cfg_we       = ($urandom_range(0, 3) == 0);
      cfg_addr     = AW'($urandom);
      cfg_x1       = XW'($urandom);
      cfg_x2       = XW'($urandom);
      cfg_t        = TW'($urandom);
      rst          = ($urandom_range(0, 200) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
